led_pwm_driver: RTL and testbench

LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

---
 rtl/led_pkg.sv | 13 +
 rtl/led_pattern_map.sv | 33 +++
 rtl/led_pwm_driver.sv | 121 ++++++++++++
 tb/tb_led_pwm_driver.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM driver: pattern mode encodings and PWM width.
package led_pkg;

  localparam int PWM_W = 8;

  typedef enum logic [1:0] {
    MODE_BIN  = 2'd0,
    MODE_BAR  = 2'd1,
    MODE_DOT  = 2'd2,
    MODE_GRAY = 2'd3
  } mode_t;

endpackage

// File: rtl/led_pattern_map.sv
// Combinational mapping of a display value to an 8-bit LED pattern per mode.
module led_pattern_map
  import led_pkg::*;
(
  input  logic [PWM_W-1:0] value,
  input  logic [1:0]       mode,
  output logic [PWM_W-1:0] pattern
);

  // Bar length rounds up in steps of 32; the 9-bit sum keeps 255+31 from wrapping.
  logic [8:0] bar_sum;
  logic [3:0] bar_n;

  assign bar_sum = {1'b0, value} + 9'd31;
  assign bar_n   = bar_sum[8:5];

  // Select the pattern for the requested mode.
  always_comb begin
    pattern = '0;
    case (mode_t'(mode))
      MODE_BIN:  pattern = value;
      MODE_BAR: begin
        for (int i = 0; i < PWM_W; i++) begin
          pattern[i] = (4'(i) < bar_n);
        end
      end
      MODE_DOT:  pattern[value[7:5]] = 1'b1;
      MODE_GRAY: pattern = value ^ (value >> 1);
      default:   pattern = value;
    endcase
  end

endmodule

// File: rtl/led_pwm_driver.sv
// Eight-LED PWM driver with a one-slot shadow register that is applied only at
// PWM period boundaries, so a displayed pattern never changes mid-period.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int PRESCALE_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] value,
  input  logic [1:0]       mode,
  input  logic [PWM_W-1:0] brightness,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             LED0,
  output logic             LED1,
  output logic             LED2,
  output logic             LED3,
  output logic             LED4,
  output logic             LED5,
  output logic             LED6,
  output logic             LED7
);

  logic             tick;
  logic [PWM_W-1:0] pwm_cnt;
  logic             boundary;
  logic             xfer;

  logic             full;
  logic [PWM_W-1:0] sh_value;
  logic [1:0]       sh_mode;
  logic [PWM_W-1:0] sh_bright;

  logic [PWM_W-1:0] act_value;
  logic [1:0]       act_mode;
  logic [PWM_W-1:0] act_bright;

  logic [PWM_W-1:0] pattern;
  logic [PWM_W-1:0] led_raw_p0;
  logic [PWM_W-1:0] led_p1;

  generate
    if (PRESCALE_LOG2 == 0) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      logic [PRESCALE_LOG2-1:0] pre_cnt;

      // Free-running prescaler; the tick fires on the cycle it wraps.
      always_ff @(posedge clk) begin
        if (rst) pre_cnt <= '0;
        else     pre_cnt <= pre_cnt + PRESCALE_LOG2'(1);
      end

      assign tick = &pre_cnt;
    end
  endgenerate

  // PWM counter advances once per tick and wraps every 256 ticks.
  always_ff @(posedge clk) begin
    if (rst)       pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign boundary = tick && (pwm_cnt == 8'hFF);
  assign in_ready = !full && !rst;
  assign xfer     = in_valid && in_ready;

  // Shadow slot fills on a handshake and drains into the active set at a boundary.
  // A fill and a drain never coincide because a fill requires the slot to be empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 1'b0;
      sh_value   <= '0;
      sh_mode    <= '0;
      sh_bright  <= '0;
      act_value  <= '0;
      act_mode   <= '0;
      act_bright <= '0;
    end else begin
      if (boundary && full) begin
        act_value  <= sh_value;
        act_mode   <= sh_mode;
        act_bright <= sh_bright;
        full       <= 1'b0;
      end
      if (xfer) begin
        sh_value  <= value;
        sh_mode   <= mode;
        sh_bright <= brightness;
        full      <= 1'b1;
      end
    end
  end

  led_pattern_map u_map (
    .value   (act_value),
    .mode    (act_mode),
    .pattern (pattern)
  );

  // ---- stage p0: gate pattern with the duty compare ----
  assign led_raw_p0 = pattern & {PWM_W{pwm_cnt < act_bright}};

  // ---- stage p1: registered LED drives ----
  // Register the gated pattern so outputs are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) led_p1 <= '0;
    else     led_p1 <= led_raw_p0;
  end

  assign LED0 = led_p1[7];
  assign LED1 = led_p1[6];
  assign LED2 = led_p1[5];
  assign LED3 = led_p1[4];
  assign LED4 = led_p1[3];
  assign LED5 = led_p1[2];
  assign LED6 = led_p1[1];
  assign LED7 = led_p1[0];

endmodule

// File: tb/tb_led_pwm_driver.sv
// Randomized and directed bench for led_pwm_driver, checked every cycle
// against a cycle-count based behavioural model.
module tb_led_pwm_driver;

  localparam int PL     = 0;
  localparam int TPP    = 1 << PL;        // clocks per tick
  localparam int PERIOD = 256 * TPP;      // clocks per PWM period

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value;
  logic [1:0] mode;
  logic [7:0] brightness;
  logic       in_valid;
  logic       in_ready;
  logic       LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;

  always #5 clk = ~clk;

  led_pwm_driver #(.PRESCALE_LOG2(PL)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .mode       (mode),
    .brightness (brightness),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .LED0       (LED0),
    .LED1       (LED1),
    .LED2       (LED2),
    .LED3       (LED3),
    .LED4       (LED4),
    .LED5       (LED5),
    .LED6       (LED6),
    .LED7       (LED7)
  );

  int checks = 0;
  int errors = 0;

  // Model state: clocks since reset release, shadow slot, active settings,
  // expected LED vector in {LED0..LED7} order (equal to the pattern bit order).
  int unsigned m_cyc;
  bit          m_full;
  bit          m_took;
  logic [7:0]  m_sv, m_sb, m_av, m_ab;
  logic [1:0]  m_sm, m_am;
  logic [7:0]  m_led;

  function automatic logic [7:0] pat(input logic [7:0] v, input logic [1:0] m);
    int n;
    case (m)
      2'd0: return v;
      2'd1: begin
        n = (int'(v) + 31) / 32;
        return 8'((1 << n) - 1);
      end
      2'd2: return 8'(1 << (int'(v) / 32));
      default: return v ^ (v >> 1);
    endcase
  endfunction

  function automatic logic [7:0] leds();
    return {LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model from the current inputs, then compare.
  task automatic step();
    int  pwm;
    bit  tick, bnd;
    logic [7:0] nled;
    m_took = 1'b0;
    if (rst) begin
      m_cyc = 0; m_full = 0; m_led = '0;
      m_sv = '0; m_sm = '0; m_sb = '0;
      m_av = '0; m_am = '0; m_ab = '0;
    end else begin
      pwm  = int'((m_cyc / TPP) % 256);
      tick = (m_cyc % TPP) == TPP - 1;
      bnd  = tick && (pwm == 255);
      nled = (pwm < int'(m_ab)) ? pat(m_av, m_am) : 8'h00;
      if (in_valid && !m_full) begin
        m_took = 1'b1;
      end
      if (bnd && m_full) begin
        m_av = m_sv; m_am = m_sm; m_ab = m_sb; m_full = 0;
      end
      if (m_took) begin
        m_sv = value; m_sm = mode; m_sb = brightness; m_full = 1;
      end
      m_cyc++;
      m_led = nled;
    end
    @(posedge clk);
    #1;
    check("leds", 32'(leds()), 32'(m_led));
    check("in_ready", 32'(in_ready), 32'(!m_full && !rst));
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic run_to_bnd();
    for (int i = 0; i < PERIOD + 8; i++) begin
      step();
      if (m_cyc % PERIOD == 0) return;
    end
    timeout("run_to_bnd");
  endtask

  task automatic send(input logic [7:0] v, input logic [1:0] m, input logic [7:0] b);
    value = v; mode = m; brightness = b; in_valid = 1'b1;
    for (int i = 0; i < 2 * PERIOD + 8; i++) begin
      step();
      if (m_took) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    timeout("send");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check("reset_leds", 32'(leds()), 32'h0);
    check("reset_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [7:0] bar_v [5];
    logic [7:0] bar_e [5];
    int         bar_n [5];
    bar_v = '{8'd0, 8'd1, 8'd32, 8'd33, 8'd255};
    bar_e = '{8'h00, 8'h01, 8'h01, 8'h03, 8'hFF};
    bar_n = '{0, 1, 1, 2, 8};

    rst = 1'b1; in_valid = 1'b0; value = '0; mode = '0; brightness = '0;
    m_cyc = 0; m_full = 0; m_took = 0; m_led = '0;
    m_sv = '0; m_sm = '0; m_sb = '0; m_av = '0; m_am = '0; m_ab = '0;
    do_reset();

    // Binary 0xA5 at half duty.
    send(8'hA5, 2'd0, 8'd128);
    check("pre_bnd_leds", 32'(leds()), 32'h0);
    run_to_bnd();
    check("bnd_leds_old", 32'(leds()), 32'h0);
    step();
    check("a5_on", 32'(leds()), 32'hA5);
    repeat (127) step();
    check("a5_last_on", 32'(leds()), 32'hA5);
    step();
    check("a5_off", 32'(leds()), 32'h00);
    cnt = 0;
    repeat (256) begin
      step();
      if (LED0) cnt++;
    end
    check("a5_duty", 32'(cnt), 32'd128);

    // Bar, dot and Gray mappings.
    for (int k = 0; k < 5; k++) begin
      send(bar_v[k], 2'd1, 8'd255);
      run_to_bnd();
      step();
      check("bar_pattern", 32'(leds()), 32'(bar_e[k]));
      check("bar_count", 32'($countones(leds())), 32'(bar_n[k]));
    end
    send(8'hE0, 2'd2, 8'd255);
    run_to_bnd();
    step();
    check("dot_e0", 32'(leds()), 32'h80);
    send(8'h80, 2'd3, 8'd255);
    run_to_bnd();
    step();
    check("gray_80", 32'(leds()), 32'hC0);

    // Back-pressure: B held while A pending.
    send(8'h0F, 2'd0, 8'd255);
    value = 8'hF0; mode = 2'd0; brightness = 8'd255; in_valid = 1'b1;
    run_to_bnd();
    check("bp_ready_after_bnd", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    check("bp_b_taken", 32'(in_ready), 32'h0);
    check("bp_a_shown", 32'(leds()), 32'h0F);
    run_to_bnd();
    step();
    check("bp_b_shown", 32'(leds()), 32'hF0);

    // Brightness extremes.
    send(8'hFF, 2'd0, 8'd0);
    run_to_bnd();
    cnt = 0;
    repeat (1024) begin
      step();
      if (leds() != 8'h00) cnt++;
    end
    check("bri0_never_on", 32'(cnt), 32'd0);
    send(8'hFF, 2'd0, 8'd255);
    run_to_bnd();
    cnt = 0;
    repeat (256) begin
      step();
      if (!LED3) cnt++;
    end
    check("bri255_low_once", 32'(cnt), 32'd1);

    // Reset mid-period with a pending shadow.
    send(8'h3C, 2'd0, 8'd200);
    run_to_bnd();
    repeat (50) step();
    send(8'h81, 2'd0, 8'd255);
    repeat (10) step();
    rst = 1'b1;
    step();
    check("midrst_leds", 32'(leds()), 32'h0);
    check("midrst_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    cnt = 0;
    repeat (256) begin
      step();
      if (leds() != 8'h00) cnt++;
    end
    check("midrst_dark", 32'(cnt), 32'd0);

    // Transfer accepted exactly in a boundary cycle.
    send(8'h55, 2'd0, 8'd255);
    run_to_bnd();
    for (int i = 0; i < PERIOD + 8 && (m_cyc % PERIOD) != PERIOD - 1; i++) step();
    value = 8'hAA; mode = 2'd0; brightness = 8'd255; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("bndx_taken", 32'(in_ready), 32'h0);
    step();
    check("bndx_old", 32'(leds()), 32'h55);
    run_to_bnd();
    step();
    check("bndx_new", 32'(leds()), 32'hAA);

    // Randomized traffic with occasional resets.
    repeat (4000) begin
      in_valid   = ($urandom_range(0, 3) == 0);
      value      = 8'($urandom);
      mode       = 2'($urandom);
      brightness = 8'($urandom);
      rst        = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
